spi_xfer_ctrl: RTL and testbench
================================

Name: spi_xfer_ctrl

Overview:
- Sequences one 8-bit SPI master transfer: slave-select assertion, SCK generation, MOSI shifting, MISO sampling and completion signalling.
- Sits between the SPI register file (control/baud fields, data register) and the pins.
- Uses the same baud formula as the SCK generator: half-period H = (sppr_in+1) << (spr_in+1) clk cycles, so H ranges 2..2048.
- Adds CPHA, bit order, SS timing and a start/busy/done handshake.

Parameters:
- DATA_W, 8, transfer width in bits. Fixed at 8 for this revision; edge count = 2*DATA_W.
- CNT_W, 12, half-period counter width. Must hold 2048.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous reset, active-high
- cpol_in  input  1  SCK idle level
- cpha_in  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge
- lsbfe_in  input  1  1 = LSB first
- sppr_in  input  3  baud prescale
- spr_in  input  3  baud shift
- start_in  input  1  transfer request, level-sampled
- tx_data_in  input  8  byte to send
- miso_in  input  1  serial input, pre-synchronised upstream
- busy_out  output  1  transfer in progress
- done_out  output  1  one-cycle completion pulse
- rx_data_out  output  8  last received byte
- sck_out  output  1  SPI clock
- mosi_out  output  1  serial output
- ss_n_out  output  1  slave select, active-low

Behaviour:
- Reset values (async, rst_in=1): state IDLE, busy_out 0, done_out 0, rx_data_out 0x00, sck_out 0, mosi_out 1, ss_n_out 1, counter 0, edge count 0.
- States: IDLE, LEAD, XFER, TRAIL, DONE.
- IDLE:
  - sck_out registers cpol_in every cycle; ss_n_out 1; mosi_out 1.
  - start_in=1 at a clk edge accepts the request: latch cpol/cpha/lsbfe/H/tx_data, go to LEAD.
  - start_in is ignored in every other state, with no queueing.
- LEAD:
  - ss_n_out 0, busy_out 1, sck_out at latched CPOL.
  - mosi_out presents the first bit: tx[7], or tx[0] if lsbfe.
  - Lasts exactly H cycles, then go to XFER.
- XFER:
  - Counter counts 0..H-1. At each wrap, sck_out toggles and the edge count increments 1..16. Odd edges are leading, even edges trailing.
  - CPHA=0: sample miso_in on odd edges. Shift the next bit onto mosi_out on even edges 2..14; edge 16 does not shift.
  - CPHA=1: on odd edges, shift the next bit onto mosi_out (edge 1 re-presents the first bit). Sample miso_in on even edges.
  - Sampling captures the miso_in value present at the clk edge where sck toggles. Received bits fill in the same order they are transmitted.
  - After edge 16, sck_out is back at CPOL; go to TRAIL.
- TRAIL: ss_n_out stays 0; mosi_out holds the last bit. Lasts H cycles, then go to DONE.
- DONE:
  - Single cycle: ss_n_out 1, busy_out 0, done_out 1, rx_data_out updated.
  - Next state IDLE.
  - rx_data_out changes only on DONE entry and otherwise holds.
- Latency: start accepted at edge t0 gives LEAD from t0+1 and done_out high in cycle t0+1+18H. The earliest next accepted start is at t0+2+18H.
- Config inputs changing mid-transfer have no effect, because all config is latched at acceptance.
- Counter arithmetic is unsigned CNT_W. H is computed in CNT_W bits; the max case (8<<8 = 2048) fits.
- Reset mid-operation aborts immediately to reset values:
  - ss_n_out rises asynchronously.
  - No done pulse; rx_data_out is cleared.
- start_in held high continuously produces back-to-back transfers, each separated by DONE plus one IDLE cycle.

Test Plan:
- Mode 0, H=2 (sppr=0, spr=0), MSB first, tx 0xA5, miso looped to mosi -> rx_data_out=0xA5, done_out in cycle t0+37, exactly 16 sck toggles, ss_n low for 36 cycles.
- Mode 3 (cpol=1, cpha=1), LSB first, sppr=2, spr=1 (H=12), tx 0x3C, miso driven 0x81 LSB first -> rx 0x81, sck idles 1, mosi sequence 0,0,1,1,1,1,0,0, done at t0+217.
- Mode 1 and mode 2, H=2, tx 0x0F, loopback -> rx 0x0F; bench checker confirms mosi changes only on the launch edge and is stable at the sampling edge.
- Max divisor, sppr=7, spr=7 (H=2048) -> first sck edge 4096 cycles after start, done at t0+36865, no counter overflow.
- Pulse start_in while busy, and change tx_data_in/cpol_in mid-transfer -> ignored; transfer completes with the original data and mode; a single done pulse.
- Assert rst_in at edge 7 of a transfer -> all outputs at reset values within the same cycle, no done_out; a following start works normally.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI master single-byte transfer sequencer: SS framing, SCK generation from the
// baud divisor, CPHA-aware MOSI launch / MISO capture and a start/busy/done handshake.
`timescale 1ns/1ps
module spi_xfer_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 12
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              cpol_in,
   input  logic              cpha_in,
   input  logic              lsbfe_in,
   input  logic [2:0]        sppr_in,
   input  logic [2:0]        spr_in,
   input  logic              start_in,
   input  logic [DATA_W-1:0] tx_data_in,
   input  logic              miso_in,
   output logic              busy_out,
   output logic              done_out,
   output logic [DATA_W-1:0] rx_data_out,
   output logic              sck_out,
   output logic              mosi_out,
   output logic              ss_n_out
);

   localparam int IDX_W  = $clog2(DATA_W);
   localparam int EDGE_W = $clog2(2 * DATA_W + 1);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);
   localparam logic [IDX_W-1:0]  TOP_IDX   = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    half_q, half_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic                lsbfe_q, lsbfe_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;
   logic                ss_n_q, ss_n_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [CNT_W-1:0]    half_calc;
   logic                wrap;
   logic [EDGE_W-1:0]   edge_nxt;
   logic                sample_edge;
   logic                launch_edge;
   logic [IDX_W-1:0]    smp_k;
   logic [IDX_W-1:0]    launch_k;
   logic [IDX_W-1:0]    rx_pos;

   function automatic logic pick_bit(input logic [DATA_W-1:0] v,
                                     input logic [IDX_W-1:0]  k,
                                     input logic              lsb_first);
      return lsb_first ? v[k] : v[TOP_IDX - k];
   endfunction

   // Half-period in clk cycles; the shift amount needs 4 bits so spr=7 does not wrap to 0.
   assign half_calc = (CNT_W'(sppr_in) + CNT_W'(1)) << ({1'b0, spr_in} + 4'd1);
   assign wrap      = (cnt_q == half_q - CNT_W'(1));

   // Edge numbers run 1..16; odd edges are leading, even edges trailing.
   assign edge_nxt    = edge_q + EDGE_W'(1);
   assign sample_edge = cpha_q ? ~edge_nxt[0] : edge_nxt[0];
   assign launch_edge = cpha_q ? edge_nxt[0] : (~edge_nxt[0] && (edge_nxt != LAST_EDGE));
   assign smp_k       = edge_q[IDX_W:1];
   assign launch_k    = cpha_q ? edge_q[IDX_W:1] : edge_nxt[IDX_W:1];
   assign rx_pos      = lsbfe_q ? smp_k : TOP_IDX - smp_k;

   // NOTE: every *_d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      edge_d  = edge_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      lsbfe_d = lsbfe_q;
      tx_d    = tx_q;
      rx_sh_d = rx_sh_q;
      rx_d    = rx_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      ss_n_d  = ss_n_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            sck_d  = cpol_in;
            ss_n_d = 1'b1;
            mosi_d = 1'b1;
            busy_d = 1'b0;
            if (start_in) begin
               cpol_d  = cpol_in;
               cpha_d  = cpha_in;
               lsbfe_d = lsbfe_in;
               half_d  = half_calc;
               tx_d    = tx_data_in;
               cnt_d   = '0;
               edge_d  = '0;
               ss_n_d  = 1'b0;
               busy_d  = 1'b1;
               mosi_d  = pick_bit(tx_data_in, {IDX_W{1'b0}}, lsbfe_in);
               state_d = LEAD;
            end
         end

         LEAD: begin
            if (wrap) begin
               cnt_d   = '0;
               state_d = XFER;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         XFER: begin
            if (wrap) begin
               cnt_d  = '0;
               sck_d  = ~sck_q;
               edge_d = edge_nxt;
               // miso_in is taken at the same clk edge that moves sck.
               if (sample_edge) rx_sh_d[rx_pos] = miso_in;
               if (launch_edge) mosi_d = pick_bit(tx_q, launch_k, lsbfe_q);
               if (edge_nxt == LAST_EDGE) state_d = TRAIL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         TRAIL: begin
            if (wrap) begin
               cnt_d   = '0;
               ss_n_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               mosi_d  = 1'b1;
               rx_d    = rx_sh_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         half_q  <= '0;
         edge_q  <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsbfe_q <= 1'b0;
         tx_q    <= '0;
         rx_sh_q <= '0;
         rx_q    <= '0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b1;
         ss_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         edge_q  <= edge_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsbfe_q <= lsbfe_d;
         tx_q    <= tx_d;
         rx_sh_q <= rx_sh_d;
         rx_q    <= rx_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         ss_n_q  <= ss_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_out    = busy_q;
   assign done_out    = done_q;
   assign rx_data_out = rx_q;
   assign sck_out     = sck_q;
   assign mosi_out    = mosi_q;
   assign ss_n_out    = ss_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: watches the pins cycle by cycle and checks
// timing, framing, bit order, phase and reset behaviour against hand-derived values.
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       cpol_in, cpha_in, lsbfe_in;
   logic [2:0] sppr_in, spr_in;
   logic       start_in;
   logic [7:0] tx_data_in;
   logic       miso_in;
   logic       busy_out, done_out;
   logic [7:0] rx_data_out;
   logic       sck_out, mosi_out, ss_n_out;

   bit         loop_en;
   logic       miso_drv;

   int checks   = 0;
   int failures = 0;

   spi_xfer_ctrl #(.DATA_W(8), .CNT_W(12)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .cpol_in     (cpol_in),
      .cpha_in     (cpha_in),
      .lsbfe_in    (lsbfe_in),
      .sppr_in     (sppr_in),
      .spr_in      (spr_in),
      .start_in    (start_in),
      .tx_data_in  (tx_data_in),
      .miso_in     (miso_in),
      .busy_out    (busy_out),
      .done_out    (done_out),
      .rx_data_out (rx_data_out),
      .sck_out     (sck_out),
      .mosi_out    (mosi_out),
      .ss_n_out    (ss_n_out)
   );

   always #5 clk_in = ~clk_in;

   assign miso_in = loop_en ? mosi_out : miso_drv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic slave_bit(input logic [7:0] b, input int k, input bit lsb);
      return lsb ? b[k] : b[7-k];
   endfunction

   // n counts clk edges after the accepting edge (n=0 is the first LEAD cycle),
   // so done_out is expected at n = 18H and the first sck edge at n = 2H.
   task automatic run_xfer(input string tag, input bit cpol, input bit cpha, input bit lsbfe,
                           input logic [2:0] sppr, input logic [2:0] spr, input logic [7:0] tx,
                           input bit loop, input logic [7:0] sbyte, input bit perturb,
                           input logic [7:0] exp_rx);
      int h, n, limit, done_n, done_cnt, edges, first_edge, ss_low, mviol, rxviol, k;
      logic prev_sck, prev_mosi, sck_chg, launch, sample, sck_at_done;
      logic [7:0] prev_rx, rx_at_done, mosi_seen;
      h = (int'(sppr) + 1) << (int'(spr) + 1);
      limit = 18 * h + 20;
      done_n = -1; done_cnt = 0; edges = 0; first_edge = -1;
      mviol = 0; rxviol = 0; mosi_seen = '0; rx_at_done = '0; sck_at_done = 1'b0;

      @(negedge clk_in);
      cpol_in = cpol; cpha_in = cpha; lsbfe_in = lsbfe;
      sppr_in = sppr; spr_in = spr; tx_data_in = tx;
      loop_en = loop; miso_drv = 1'b0;
      @(posedge clk_in); #1;
      check({tag, "_idle_sck"}, 32'(sck_out), 32'(cpol));

      @(negedge clk_in);
      start_in = 1'b1;
      @(posedge clk_in); #1;
      start_in = 1'b0;
      check({tag, "_lead_busy_ssn"}, {30'd0, busy_out, ss_n_out}, 32'b10);
      check({tag, "_first_bit"}, 32'(mosi_out), 32'(lsbfe ? tx[0] : tx[7]));
      if (!loop && !cpha) miso_drv = slave_bit(sbyte, 0, lsbfe);
      ss_low    = (ss_n_out === 1'b0) ? 1 : 0;
      prev_sck  = sck_out;
      prev_mosi = mosi_out;
      prev_rx   = rx_data_out;

      for (n = 1; n < limit; n++) begin
         @(posedge clk_in); #1;
         if (perturb && n == 5) begin
            start_in = 1'b1; tx_data_in = ~tx; cpol_in = ~cpol;
         end
         if (perturb && n == 6) start_in = 1'b0;

         sck_chg = (sck_out !== prev_sck) && (done_n < 0);
         launch  = 1'b0;
         sample  = 1'b0;
         if (sck_chg) begin
            edges++;
            if (edges == 1) first_edge = n;
            launch = cpha ? (edges % 2 == 1) : ((edges % 2 == 0) && (edges != 16));
            sample = cpha ? (edges % 2 == 0) : (edges % 2 == 1);
         end
         if ((mosi_out !== prev_mosi) && !launch && (done_out !== 1'b1)) mviol++;
         if (sample && edges <= 16) begin
            k = (edges - 1) / 2;
            mosi_seen[lsbfe ? k : 7 - k] = prev_mosi;
         end
         if (!loop && sck_chg) begin
            if (!cpha && (edges % 2 == 0) && edges < 16) miso_drv = slave_bit(sbyte, edges / 2, lsbfe);
            if (cpha && (edges % 2 == 1)) miso_drv = slave_bit(sbyte, (edges - 1) / 2, lsbfe);
         end
         if (ss_n_out === 1'b0) ss_low++;
         if ((rx_data_out !== prev_rx) && (done_out !== 1'b1)) rxviol++;
         if (done_out === 1'b1) begin
            done_cnt++;
            if (done_n < 0) begin
               done_n      = n;
               rx_at_done  = rx_data_out;
               sck_at_done = sck_out;
               cpol_in     = cpol;
               tx_data_in  = tx;
            end
         end
         prev_sck  = sck_out;
         prev_mosi = mosi_out;
         prev_rx   = rx_data_out;
         if (done_n >= 0 && n >= done_n + 3) break;
      end

      check({tag, "_done_lat"},   32'(done_n),     32'(18 * h));
      check({tag, "_done_count"}, 32'(done_cnt),   32'd1);
      check({tag, "_sck_edges"},  32'(edges),      32'd16);
      check({tag, "_first_edge"}, 32'(first_edge), 32'(2 * h));
      check({tag, "_ss_low"},     32'(ss_low),     32'(18 * h));
      check({tag, "_rx"},         32'(rx_at_done), 32'(exp_rx));
      check({tag, "_mosi_bits"},  32'(mosi_seen),  32'(tx));
      check({tag, "_mosi_phase"}, 32'(mviol),      32'd0);
      check({tag, "_rx_hold"},    32'(rxviol),     32'd0);
      check({tag, "_sck_done"},   32'(sck_at_done), 32'(cpol));
      check({tag, "_noqueue"},    32'(busy_out),   32'd0);
   endtask

   initial begin
      int e, dcnt, n;
      logic prev;
      rst_in = 1'b1; cpol_in = 1'b1; cpha_in = 1'b0; lsbfe_in = 1'b0;
      sppr_in = '0; spr_in = '0; start_in = 1'b0; tx_data_in = '0;
      loop_en = 1'b1; miso_drv = 1'b0;
      #1;
      check("rst_sck",  32'(sck_out),     32'd0);
      check("rst_ssn",  32'(ss_n_out),    32'd1);
      check("rst_mosi", 32'(mosi_out),    32'd1);
      check("rst_busy", 32'(busy_out),    32'd0);
      check("rst_done", 32'(done_out),    32'd0);
      check("rst_rx",   32'(rx_data_out), 32'd0);
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;

      // mode 0, H=2, MSB first, loopback
      run_xfer("m0",   1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'hA5, 1'b1, 8'h00, 1'b0, 8'hA5);
      // mode 3, H=12, LSB first, slave returns 0x81
      run_xfer("m3",   1'b1, 1'b1, 1'b1, 3'd2, 3'd1, 8'h3C, 1'b0, 8'h81, 1'b0, 8'h81);
      // modes 1 and 2, H=2, loopback
      run_xfer("m1",   1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h0F, 1'b1, 8'h00, 1'b0, 8'h0F);
      run_xfer("m2",   1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h0F, 1'b1, 8'h00, 1'b0, 8'h0F);
      // largest divisor, H=2048
      run_xfer("hmax", 1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 8'h5A, 1'b1, 8'h00, 1'b0, 8'h5A);
      // start/tx/cpol disturbed while busy, H=4
      run_xfer("pert", 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 8'hC3, 1'b1, 8'h00, 1'b1, 8'hC3);

      // reset at the 7th sck edge of a transfer
      @(negedge clk_in);
      cpol_in = 1'b0; cpha_in = 1'b0; lsbfe_in = 1'b0; sppr_in = 3'd0; spr_in = 3'd0;
      tx_data_in = 8'h69; loop_en = 1'b1; start_in = 1'b1;
      @(posedge clk_in); #1;
      start_in = 1'b0;
      e = 0;
      prev = sck_out;
      for (int i = 0; i < 200 && e < 7; i++) begin
         @(posedge clk_in); #1;
         if (sck_out !== prev) e++;
         prev = sck_out;
      end
      check("rst7_reach", 32'(e), 32'd7);
      rst_in = 1'b1;
      #1;
      check("rst7_outs", {26'd0, sck_out, ss_n_out, mosi_out, busy_out, done_out},
            32'b01100);
      check("rst7_rx", 32'(rx_data_out), 32'd0);
      dcnt = 0;
      repeat (3) begin
         @(posedge clk_in); #1;
         if (done_out !== 1'b0) dcnt++;
      end
      check("rst7_nodone", 32'(dcnt), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      run_xfer("post", 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'h96, 1'b1, 8'h00, 1'b0, 8'h96);

      // start held high: DONE, one IDLE cycle, then the next LEAD
      @(negedge clk_in);
      cpol_in = 1'b0; cpha_in = 1'b0; lsbfe_in = 1'b0; sppr_in = 3'd0; spr_in = 3'd0;
      tx_data_in = 8'h33; start_in = 1'b1;
      n = 0;
      do begin
         @(posedge clk_in); #1;
         n++;
      end while (done_out !== 1'b1 && n < 100);
      check("b2b_first_done", 32'(done_out), 32'd1);
      @(posedge clk_in); #1;
      check("b2b_idle", {30'd0, busy_out, done_out}, 32'b00);
      @(posedge clk_in); #1;
      check("b2b_restart", {30'd0, busy_out, ss_n_out}, 32'b10);
      start_in = 1'b0;
      n = 0;
      do begin
         @(posedge clk_in); #1;
         n++;
      end while (done_out !== 1'b1 && n < 100);
      check("b2b_second_lat", 32'(n), 32'd36);
      check("b2b_second_rx", 32'(rx_data_out), 32'h33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
